// File: rtl/vector_processor_pkg.sv
// Shared vector-processor definitions: default sizing, dispatch queue entry
// layout and the completion-handshake state encoding.
package vector_processor_pkg;

  localparam int VP_DEPTH   = 4;
  localparam int VP_DATA_W  = 32;
  localparam int VP_MAX_OUT = 2;
  localparam int VP_INST_W  = 32;

  // One queued vector instruction with its scalar operands (default width).
  typedef struct packed {
    logic [VP_INST_W-1:0] instruction;
    logic [VP_DATA_W-1:0] rs1;
    logic [VP_DATA_W-1:0] rs2;
  } vq_entry_t;

  // Four-phase completion handshake, value doubles as scalar_pro_ready.
  typedef enum logic {
    ACK_IDLE  = 1'b0,
    ACK_ACKED = 1'b1
  } ack_state_t;

endpackage

// File: rtl/vec_dispatch_fifo.sv
// Circular dispatch queue: storage, wrap-around pointers and occupancy.
// Push/pop qualification is done by the caller; flush empties the queue.
module vec_dispatch_fifo
  import vector_processor_pkg::*;
#(
  parameter int  DEPTH   = VP_DEPTH,
  parameter type entry_t = vq_entry_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  entry_t                     wdata,
  output entry_t                     rdata,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  // Entry storage; contents are never cleared, only pointers matter.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (occupancy == CW'(DEPTH));
  assign empty = (occupancy == '0);

endmodule

// File: rtl/vec_dispatch_queue.sv
// Scalar-to-vector dispatch queue. Vector instructions seen by the scalar
// pipe are queued with their operands, issued to the vector unit under a
// credit limit (MAX_OUT), and credits return through a four-phase ack.
module vec_dispatch_queue
  import vector_processor_pkg::*;
#(
  parameter int DEPTH   = VP_DEPTH,
  parameter int DATA_W  = VP_DATA_W,
  parameter int MAX_OUT = VP_MAX_OUT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         is_vec,
  input  logic [31:0]                  instruction,
  input  logic [DATA_W-1:0]            rs1_data,
  input  logic [DATA_W-1:0]            rs2_data,
  input  logic                         flush,
  output logic                         pc_enable,
  output logic                         vec_inst_valid,
  output logic [31:0]                  vec_instruction,
  output logic [DATA_W-1:0]            vec_rs1,
  output logic [DATA_W-1:0]            vec_rs2,
  input  logic                         vec_pro_ready,
  input  logic                         vec_pro_ack,
  output logic                         scalar_pro_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
  output logic                         ack_err
);

  localparam int OW = $clog2(MAX_OUT+1);

  // Same layout as vq_entry_t, resized to this instance's operand width.
  typedef struct packed {
    logic [31:0]       instruction;
    logic [DATA_W-1:0] rs1;
    logic [DATA_W-1:0] rs2;
  } entry_t;

  entry_t     wdata, head;
  logic       full, empty, push, pop, completion;
  ack_state_t state_q, state_d;

  assign push           = is_vec & ~full & ~flush;
  assign pc_enable      = ~is_vec | (~full & ~flush);
  assign vec_inst_valid = ~empty & (outstanding < OW'(MAX_OUT)) & ~flush;
  assign pop            = vec_inst_valid & vec_pro_ready;

  assign wdata = '{instruction: instruction, rs1: rs1_data, rs2: rs2_data};

  vec_dispatch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .wdata     (wdata),
    .rdata     (head),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty)
  );

  assign vec_instruction = head.instruction;
  assign vec_rs1         = head.rs1;
  assign vec_rs2         = head.rs2;

  // Completion handshake state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ACK_IDLE;
    else     state_q <= state_d;
  end

  // Next state; a completion is counted only on the IDLE->ACKED step.
  always_comb begin
    state_d    = state_q;
    completion = 1'b0;
    case (state_q)
      ACK_IDLE: if (vec_pro_ack) begin
        state_d    = ACK_ACKED;
        completion = 1'b1;
      end
      ACK_ACKED: if (!vec_pro_ack) state_d = ACK_IDLE;
      default:   state_d = ACK_IDLE;
    endcase
  end

  assign scalar_pro_ready = (state_q == ACK_ACKED);

  // Issued-but-uncompleted credit count; a completion with nothing
  // outstanding saturates at zero and latches the error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      ack_err     <= 1'b0;
    end else begin
      case ({pop, completion})
        2'b10: outstanding <= outstanding + 1'b1;
        2'b01: begin
          if (outstanding == '0) ack_err     <= 1'b1;
          else                   outstanding <= outstanding - 1'b1;
        end
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_dispatch_queue.sv
// Self-checking bench for vec_dispatch_queue: a queue-based reference model
// checked against the DUT every cycle, plus directed literal expectations.
module tb_vec_dispatch_queue;

  localparam int DEPTH   = 4;
  localparam int DATA_W  = 32;
  localparam int MAX_OUT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              is_vec, flush, vec_pro_ready, vec_pro_ack;
  logic [31:0]       instruction;
  logic [DATA_W-1:0] rs1_data, rs2_data;
  logic              pc_enable, vec_inst_valid, scalar_pro_ready, ack_err;
  logic [31:0]       vec_instruction;
  logic [DATA_W-1:0] vec_rs1, vec_rs2;
  logic [$clog2(DEPTH+1)-1:0]   occupancy;
  logic [$clog2(MAX_OUT+1)-1:0] outstanding;

  vec_dispatch_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)) dut (
    .clk              (clk),
    .rst              (rst),
    .is_vec           (is_vec),
    .instruction      (instruction),
    .rs1_data         (rs1_data),
    .rs2_data         (rs2_data),
    .flush            (flush),
    .pc_enable        (pc_enable),
    .vec_inst_valid   (vec_inst_valid),
    .vec_instruction  (vec_instruction),
    .vec_rs1          (vec_rs1),
    .vec_rs2          (vec_rs2),
    .vec_pro_ready    (vec_pro_ready),
    .vec_pro_ack      (vec_pro_ack),
    .scalar_pro_ready (scalar_pro_ready),
    .occupancy        (occupancy),
    .outstanding      (outstanding),
    .ack_err          (ack_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the queue as a list of entries, credits as an integer.
  typedef struct {
    logic [31:0]       i;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] issued[$];
  int          m_out    = 0;
  bit          m_ack_hi = 1'b0;
  bit          m_err    = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_out    = 0;
      m_ack_hi = 1'b0;
      m_err    = 1'b0;
    end else begin : upd
      bit v, p, u, c;
      ent_t e;
      v = (mq.size() > 0) && (m_out < MAX_OUT) && !flush;
      p = v && vec_pro_ready;
      u = is_vec && (mq.size() < DEPTH) && !flush;
      c = !m_ack_hi && vec_pro_ack;
      if (flush) mq.delete();
      else begin
        if (p) begin
          issued.push_back(mq[0].i);
          void'(mq.pop_front());
        end
        if (u) begin
          e.i = instruction; e.a = rs1_data; e.b = rs2_data;
          mq.push_back(e);
        end
      end
      if (p) m_out++;
      if (c) begin
        if (m_out > 0) m_out--;
        else           m_err = 1'b1;
      end
      m_ack_hi = vec_pro_ack;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin : cmp
    bit ev, epc;
    ev  = (mq.size() > 0) && (m_out < MAX_OUT) && !flush && !rst;
    epc = !is_vec || ((mq.size() < DEPTH) && !flush && !rst) || (rst && !is_vec);
    chk("occupancy", occupancy, mq.size());
    chk("outstanding", outstanding, m_out);
    chk("vec_inst_valid", vec_inst_valid, ev);
    if (!rst) chk("pc_enable", pc_enable, epc);
    chk("scalar_pro_ready", scalar_pro_ready, m_ack_hi);
    chk("ack_err", ack_err, m_err);
    if (ev) begin
      chk("vec_instruction", vec_instruction, mq[0].i);
      chk("vec_rs1", vec_rs1, mq[0].a);
      chk("vec_rs2", vec_rs2, mq[0].b);
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ack_pulse();
    vec_pro_ack = 1'b1; cyc(1);
    vec_pro_ack = 1'b0; cyc(1);
  endtask

  initial begin : stim
    int base, i, guard;
    bit acc;
    rst = 1'b1; is_vec = 1'b0; flush = 1'b0; vec_pro_ready = 1'b0;
    vec_pro_ack = 1'b0; instruction = '0; rs1_data = '0; rs2_data = '0;
    cyc(2);
    chk("reset occupancy", occupancy, 0);
    chk("reset valid", vec_inst_valid, 0);
    chk("reset ack_err", ack_err, 0);
    rst = 1'b0;

    // Three queued entries, then reset mid-stream.
    is_vec = 1'b1;
    for (int k = 0; k < 3; k++) begin
      instruction = 32'h100 + k; rs1_data = $urandom; rs2_data = $urandom;
      cyc(1);
    end
    is_vec = 1'b0;
    chk("three queued", occupancy, 3);
    chk("head first in", vec_instruction, 32'h100);
    rst = 1'b1;
    #1;
    chk("midreset occupancy", occupancy, 0);
    chk("midreset outstanding", outstanding, 0);
    chk("midreset valid", vec_inst_valid, 0);
    chk("midreset scalar_pro_ready", scalar_pro_ready, 0);
    cyc(1);
    rst = 1'b0;

    // Credit limit.
    is_vec = 1'b1;
    for (int k = 0; k < 3; k++) begin
      instruction = 32'h200 + k; rs1_data = $urandom; rs2_data = $urandom;
      cyc(1);
    end
    is_vec = 1'b0;
    vec_pro_ready = 1'b1;
    cyc(4);
    chk("credit outstanding", outstanding, 2);
    chk("credit occupancy", occupancy, 1);
    chk("credit valid", vec_inst_valid, 0);
    vec_pro_ack = 1'b1; cyc(1);
    chk("ack outstanding", outstanding, 1);
    chk("ack scalar_pro_ready", scalar_pro_ready, 1);
    chk("ack valid", vec_inst_valid, 1);
    vec_pro_ack = 1'b0; cyc(1);
    chk("third issued outstanding", outstanding, 2);
    chk("third issued occupancy", occupancy, 0);
    chk("third issued instr", issued[issued.size()-1], 32'h202);
    vec_pro_ready = 1'b0;
    ack_pulse(); ack_pulse();
    chk("drained", outstanding, 0);

    // Fill to full.
    is_vec = 1'b1;
    for (int k = 0; k < 6; k++) begin
      instruction = 32'h300 + k; rs1_data = $urandom; rs2_data = $urandom;
      cyc(1);
    end
    chk("fill occupancy", occupancy, 4);
    chk("fill pc_enable", pc_enable, 0);
    is_vec = 1'b0;

    // Flush with two queued and two outstanding.
    vec_pro_ready = 1'b1; cyc(2); vec_pro_ready = 1'b0;
    chk("preflush occupancy", occupancy, 2);
    flush = 1'b1; is_vec = 1'b1; instruction = 32'hdead;
    #1;
    chk("flush pc_enable", pc_enable, 0);
    chk("flush valid", vec_inst_valid, 0);
    cyc(1);
    chk("flush occupancy", occupancy, 0);
    chk("flush outstanding", outstanding, 2);
    flush = 1'b0; is_vec = 1'b0;
    ack_pulse(); ack_pulse();

    // Completion with nothing outstanding.
    chk("pre-err outstanding", outstanding, 0);
    vec_pro_ack = 1'b1; #1;
    chk("ready lags ack", scalar_pro_ready, 0);
    cyc(1);
    chk("err set", ack_err, 1);
    chk("err scalar_pro_ready", scalar_pro_ready, 1);
    chk("err outstanding", outstanding, 0);
    vec_pro_ack = 1'b0; cyc(3);
    chk("err sticky", ack_err, 1);
    chk("err ready drop", scalar_pro_ready, 0);

    // Wrap: ten instructions through the 4-deep queue.
    base = issued.size(); i = 0; guard = 0;
    vec_pro_ready = 1'b1;
    while (i < 10 && guard < 200) begin
      instruction = 32'h57 + i; rs1_data = $urandom; rs2_data = $urandom;
      is_vec = 1'b1; vec_pro_ack = guard[0];
      @(negedge clk) acc = pc_enable;
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
    end
    is_vec = 1'b0;
    chk("wrap pushes done", i, 10);
    for (int k = 0; k < 40; k++) begin
      vec_pro_ack = k[0];
      cyc(1);
    end
    vec_pro_ack = 1'b0; vec_pro_ready = 1'b0;
    cyc(2);
    chk("wrap issued count", issued.size() - base, 10);
    for (int k = 0; k < 10 && base + k < issued.size(); k++)
      chk("wrap order", issued[base+k], 32'h57 + k);
    chk("wrap occupancy", occupancy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
